// File: rtl/adc_ctrl_seq_pkg.sv
// Shared definitions for the touch-panel ADC sequencer: state encoding,
// command bytes, frame tick landmarks and the registered pin bundle.
package adc_ctrl_seq_pkg;

  localparam int CNT_W = 7;

  localparam logic [7:0]       CMD_X       = 8'hD0;
  localparam logic [7:0]       CMD_Y       = 8'h90;
  localparam logic [CNT_W-1:0] CMD_TICKS   = 7'd16;
  localparam logic [CNT_W-1:0] Y_CMD_START = 7'd32;
  localparam logic [CNT_W-1:0] Y_CMD_END   = Y_CMD_START + CMD_TICKS;
  localparam logic [CNT_W-1:0] LAST_TICK   = 7'd73;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic             cs_n;
    logic             dclk;
    logic             din;
    logic [CNT_W-1:0] count;
    logic             enable;
    logic             coord_valid;
  } pin_out_t;

  localparam pin_out_t PIN_IDLE = '{1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0};

endpackage

// File: rtl/adc_tick_gen.sv
// Tick divider: counts 0..DIV-1 and flags the last CLK of every tick.
// tick is registered; tick_nxt is its D input for callers that register a gated copy.
module adc_tick_gen #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic tick_nxt
);

  localparam int             DW   = $clog2(DIV);
  localparam logic [DW-1:0]  LAST = DW'(DIV - 1);
  localparam logic [DW-1:0]  PRE  = DW'(DIV - 2);

  logic [DW-1:0] cnt;

  // Strobe is decided one cycle early so it lands on the cnt==DIV-1 cycle.
  assign tick_nxt = !clear && (cnt == PRE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tick_nxt;
      if (clear || cnt == LAST) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_ctrl_seq.sv
// Touch ADC frame sequencer: CS_n/DCLK/DIN generation plus COUNT/ENABLE for capture.
// Optional ADC_CTRL_PENIRQ_EN gates frame start on a synchronized pen-down flag.
module adc_ctrl_seq
  import adc_ctrl_seq_pkg::*;
#(
  parameter int DIV       = 25,
  parameter int GAP_TICKS = 1000
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             RUN,
  input  logic             PENIRQ_n,
  output logic             ADC_CS_n,
  output logic             ADC_DCLK,
  output logic             ADC_DIN,
  output logic [CNT_W-1:0] COUNT,
  output logic             ENABLE,
  output logic             COORD_VALID
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);

  seq_state_e       state, state_nxt;
  pin_out_t         pins, pins_nxt;
  logic [15:0]      gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [2:0]       cmd_idx;
  logic             din_nxt;
  logic             tick, tick_nxt, div_clear, start;

`ifdef ADC_CTRL_PENIRQ_EN
  logic pen_s1, pen_s2;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      pen_s1 <= 1'b1;
      pen_s2 <= 1'b1;
    end else begin
      pen_s1 <= PENIRQ_n;
      pen_s2 <= pen_s1;
    end
  end

  assign start = RUN && !pen_s2;
`else
  logic unused_penirq;
  assign unused_penirq = PENIRQ_n;
  assign start         = RUN;
`endif

  // Divider held at zero while idle so a frame always opens on a fresh tick.
  assign div_clear = (state == ST_IDLE);

  adc_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (CLK),
    .rst_n    (RST_n),
    .clear    (div_clear),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state   <= ST_IDLE;
      pins    <= PIN_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pins    <= pins_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CONV;
      ST_CONV: if (tick && pins.count == LAST_TICK) state_nxt = ST_GAP;
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            state_nxt   = ST_IDLE;
            gap_cnt_nxt = '0;
          end else begin
            gap_cnt_nxt = gap_cnt + 16'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    count_nxt = '0;
    if (state == ST_CONV && state_nxt == ST_CONV)
      count_nxt = tick ? pins.count + 7'd1 : pins.count;
  end

  // Y window starts on a multiple of 16, so both commands share one bit select.
  assign cmd_idx = ~count_nxt[3:1];

  always_comb begin
    din_nxt = 1'b0;
    if (count_nxt < CMD_TICKS)
      din_nxt = CMD_X[cmd_idx];
    else if (count_nxt >= Y_CMD_START && count_nxt < Y_CMD_END)
      din_nxt = CMD_Y[cmd_idx];
  end

  always_comb begin
    pins_nxt             = PIN_IDLE;
    pins_nxt.coord_valid = (state == ST_CONV) && (state_nxt == ST_GAP);
    if (state_nxt == ST_CONV) begin
      pins_nxt.cs_n   = 1'b0;
      pins_nxt.count  = count_nxt;
      pins_nxt.dclk   = count_nxt[0];
      pins_nxt.din    = din_nxt;
      pins_nxt.enable = tick_nxt;
    end
  end

  assign ADC_CS_n    = pins.cs_n;
  assign ADC_DCLK    = pins.dclk;
  assign ADC_DIN     = pins.din;
  assign COUNT       = pins.count;
  assign ENABLE      = pins.enable;
  assign COORD_VALID = pins.coord_valid;

endmodule

// File: tb/tb_adc_ctrl_seq.sv
// Bench for adc_ctrl_seq: frame-timeline reference model, serial ADC model
// with capture stage, directed corner cases and randomized RUN/PENIRQ_n/reset.
module tb_adc_ctrl_seq;

  localparam int DIV   = 4;
  localparam int GAP   = 2;
  localparam int FRAME = 74 * DIV;
  localparam logic [11:0] X_VAL = 12'hA5C;
  localparam logic [11:0] Y_VAL = 12'h3F1;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       RUN = 1'b0;
  logic       PENIRQ_n = 1'b1;
  logic       ADC_CS_n, ADC_DCLK, ADC_DIN, ENABLE, COORD_VALID;
  logic [6:0] COUNT;

  int total = 0;
  int bad   = 0;
  int frames = 0;

  adc_ctrl_seq #(.DIV(DIV), .GAP_TICKS(GAP)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .RUN         (RUN),
    .PENIRQ_n    (PENIRQ_n),
    .ADC_CS_n    (ADC_CS_n),
    .ADC_DCLK    (ADC_DCLK),
    .ADC_DIN     (ADC_DIN),
    .COUNT       (COUNT),
    .ENABLE      (ENABLE),
    .COORD_VALID (COORD_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a frame is a timeline t=0..74*DIV-1, the gap t=0..GAP*DIV-1.
  int ph = 0;  // 0 idle, 1 frame, 2 gap
  int t  = 0;
  bit live = 1'b0;
  bit m_s1 = 1'b1, m_s2 = 1'b1;

  always @(posedge CLK) begin
    int nph, nt;
    bit go;
`ifdef ADC_CTRL_PENIRQ_EN
    go = RUN && !m_s2;
`else
    go = RUN;
`endif
    nph = ph;
    nt  = t;
    if (!RST_n) begin
      nph = 0;
      nt  = 0;
      m_s1 <= 1'b1;
      m_s2 <= 1'b1;
      live <= 1'b1;
    end else begin
`ifdef ADC_CTRL_PENIRQ_EN
      m_s1 <= PENIRQ_n;
      m_s2 <= m_s1;
`endif
      case (ph)
        0: if (go) begin nph = 1; nt = 0; end
        1: begin nt = t + 1; if (nt == FRAME) begin nph = 2; nt = 0; end end
        default: begin nt = t + 1; if (nt == GAP * DIV) begin nph = 0; nt = 0; end end
      endcase
    end
    ph <= nph;
    t  <= nt;
  end

  function automatic logic [11:0] exp_pins(input int p, input int tt);
    logic [7:0] cx, cy;
    int c;
    logic cs, dc, di, en, cv;
    cx = 8'hD0; cy = 8'h90;
    cs = 1'b1; dc = 1'b0; di = 1'b0; en = 1'b0; cv = 1'b0; c = 0;
    if (p == 1) begin
      c  = tt / DIV;
      cs = 1'b0;
      en = (tt % DIV) == DIV - 1;
      dc = (c % 2) == 1;
      if (c < 16)                di = cx[7 - c / 2];
      else if (c >= 32 && c < 48) di = cy[7 - (c - 32) / 2];
    end
    if (p == 2 && tt == 0) cv = 1'b1;
    return {cs, dc, di, 7'(c), en, cv};
  endfunction

  always @(negedge CLK)
    if (live)
      chk("pins", 32'({ADC_CS_n, ADC_DCLK, ADC_DIN, COUNT, ENABLE, COORD_VALID}), 32'(exp_pins(ph, t)));

  // Serial ADC model (DOUT moves on DCLK falls) and a capture stage on ENABLE.
  function automatic logic adc_bit(input int f);
    logic [11:0] xv, yv;
    xv = X_VAL; yv = Y_VAL;
    if (f >= 9 && f <= 20)  return xv[11 - (f - 9)];
    if (f >= 25 && f <= 36) return yv[11 - (f - 25)];
    return 1'b0;
  endfunction

  logic        dclk_q = 1'b0, cs_q = 1'b1, dout = 1'b0;
  int          cs_low = 0, rises = 0, falls = 0;
  logic [36:0] din_sr = '0;
  logic [11:0] xc = '0, yc = '0;

  always @(negedge CLK) begin
    if (cs_q === 1'b1 && ADC_CS_n === 1'b0) begin
      cs_low = 0; rises = 0; falls = 0; din_sr = '0; xc = '0; yc = '0; dout = 1'b0;
    end
    if (ADC_CS_n === 1'b0) begin
      cs_low++;
      if (ADC_DCLK && !dclk_q) begin rises++; din_sr = {din_sr[35:0], ADC_DIN}; end
      if (!ADC_DCLK && dclk_q) begin falls++; dout = adc_bit(falls); end
    end
    if (ENABLE === 1'b1 && COUNT[0]) begin
      if (COUNT >= 7'd19 && COUNT <= 7'd41) xc = {xc[10:0], dout};
      if (COUNT >= 7'd51 && COUNT <= 7'd73) yc = {yc[10:0], dout};
    end
    if (COORD_VALID === 1'b1) begin
      frames++;
      chk("cs_low_len", 32'(cs_low), 32'(FRAME));
      chk("dclk_rises", 32'(rises), 32'd37);
      chk("cmd_x", 32'(din_sr[36:29]), 32'h0D0);
      chk("cmd_y", 32'(din_sr[20:13]), 32'h090);
      chk("x_coord", 32'(xc), 32'(X_VAL));
      chk("y_coord", 32'(yc), 32'(Y_VAL));
    end
    dclk_q = ADC_DCLK;
    cs_q   = ADC_CS_n;
  end

  task automatic wait_cv(input string tag);
    int n = 0;
    @(negedge CLK);
    while (COORD_VALID !== 1'b1 && n < 3000) begin @(negedge CLK); n++; end
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_count(input string tag, input int c);
    int n = 0;
    while (COUNT !== 7'(c) && n < 3000) begin @(negedge CLK); n++; end
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int n;
    RST_n = 1'b0; RUN = 1'b0; PENIRQ_n = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_pins", 32'({ADC_CS_n, ADC_DCLK, ADC_DIN, COUNT, ENABLE, COORD_VALID}), 32'h800);
    RST_n = 1'b1;
    repeat (5) @(negedge CLK);
    chk("idle_no_run", 32'(ADC_CS_n), 32'd1);

    // Full frame, then back-to-back restart spacing.
    PENIRQ_n = 1'b0;
    RUN = 1'b1;
    wait_cv("first_frame_done");
    n = 0;
    do begin @(negedge CLK); n++; end while (ADC_CS_n === 1'b1 && n < 100);
    chk("cv_to_cs_fall", 32'(n), 32'(GAP * DIV + 1));

    // RUN dropped mid-frame: frame completes, then stays idle.
    wait_count("wait_c20", 20);
    RUN = 1'b0;
    wait_cv("drop_frame_done");
    repeat (GAP * DIV + 40) @(negedge CLK);
    chk("drop_idle_cs", 32'(ADC_CS_n), 32'd1);
    chk("drop_idle_cnt", 32'(COUNT), 32'd0);

    // Reset in the middle of a conversion.
    RUN = 1'b1;
    wait_count("wait_c40", 40);
    RST_n = 1'b0;
    @(negedge CLK);
    chk("mid_rst_cs", 32'(ADC_CS_n), 32'd1);
    chk("mid_rst_cnt", 32'(COUNT), 32'd0);
    chk("mid_rst_en", 32'(ENABLE), 32'd0);
    RST_n = 1'b1;
    n = 0;
    while (ADC_CS_n === 1'b1 && n < 100) begin @(negedge CLK); n++; end
    chk("restart_cnt", 32'(COUNT), 32'd0);
    wait_cv("restart_frame_done");

    // Randomized RUN / PENIRQ_n with rare resets.
    for (int s = 0; s < 40; s++) begin
      RUN      = ($urandom_range(0, 3) != 0);
      PENIRQ_n = 1'($urandom_range(0, 1));
      n        = $urandom_range(1, 400);
      for (int k = 0; k < n; k++) begin
        @(negedge CLK);
        if ($urandom_range(0, 63) == 0)   PENIRQ_n = ~PENIRQ_n;
        if ($urandom_range(0, 2999) == 0) RST_n = 1'b0;
        else                              RST_n = 1'b1;
      end
    end
    RST_n = 1'b1;
    repeat (10) @(negedge CLK);
    chk("frames_seen", 32'(frames > 3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
